// File: rtl/max_pool_2x2_stream.sv
// max_pool_2x2_stream
//   Streaming 2x2, stride-2 max-pool engine. Pixels arrive in raster order
//   with channels interleaved (channel fastest, then column, then row).
//   A per-channel holding register keeps the even-column pixel. A half-width
//   line buffer keeps the horizontal pair maxima of each even row. On every
//   odd-row/odd-column pixel the full 2x2 maximum is registered to the output.
//
// Ports
//   clk        : rising-edge clock
//   rst_n      : asynchronous active-low reset
//   clr        : synchronous frame abort (highest priority)
//   in_valid   : input pixel valid
//   in_ready   : engine can accept a pixel
//   in_data    : input pixel (DATA_W)
//   out_valid  : pooled pixel valid
//   out_ready  : downstream accepts the pooled pixel
//   out_data   : pooled pixel (DATA_W)
//   out_last   : marks the final pooled pixel of a frame
//   frame_done : one-cycle pulse after the final pooled pixel is accepted
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. out_data/out_last hold while out_valid=1 and out_ready=0.
// in_ready = ~out_valid | out_ready, so a new result can only be produced
// when the single output register is empty or being drained that same cycle.
module max_pool_2x2_stream #(
  parameter int DATA_W   = 16,
  parameter int IMG_W    = 32,
  parameter int IMG_H    = 32,
  parameter int CHANNELS = 1,
  parameter int SIGNED   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              frame_done
);

  localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int COL_W    = $clog2(IMG_W);
  localparam int ROW_W    = $clog2(IMG_H);
  localparam int LB_DEPTH = (IMG_W / 2) * CHANNELS;
  localparam int AW       = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;

  logic [CH_W-1:0]   ch;
  logic [COL_W-1:0]  col;
  logic [ROW_W-1:0]  row;
  logic [DATA_W-1:0] hold [CHANNELS];
  logic [DATA_W-1:0] lb   [LB_DEPTH];

  logic              accept;
  logic              ch_last;
  logic              col_last;
  logic              row_last;
  logic              produce;
  logic              is_last;
  logic [AW-1:0]     lb_addr;
  logic [DATA_W-1:0] hold_cur;
  logic [DATA_W-1:0] lb_cur;
  logic [DATA_W-1:0] pair_max;
  logic [DATA_W-1:0] pool_max;

  function automatic logic a_gt_b(input logic [DATA_W-1:0] a,
                                  input logic [DATA_W-1:0] b);
    if (SIGNED != 0) return $signed(a) > $signed(b);
    else             return a > b;
  endfunction

  // Ties return b; both operands are equal so the result is the same.
  function automatic logic [DATA_W-1:0] vmax(input logic [DATA_W-1:0] a,
                                             input logic [DATA_W-1:0] b);
    return a_gt_b(a, b) ? a : b;
  endfunction

  // Held low during reset so nothing is accepted before the engine is live.
  assign in_ready = rst_n & (~out_valid | out_ready);
  assign accept   = in_valid & in_ready & ~clr;

  assign ch_last  = (ch  == CH_W'(CHANNELS - 1));
  assign col_last = (col == COL_W'(IMG_W - 1));
  assign row_last = (row == ROW_W'(IMG_H - 1));
  assign is_last  = row_last & col_last & ch_last;

  // One line-buffer slot per (column pair, channel).
  assign lb_addr  = AW'((int'(col) >> 1) * CHANNELS + int'(ch));
  assign hold_cur = hold[ch];
  assign lb_cur   = lb[lb_addr];
  assign pair_max = vmax(hold_cur, in_data);
  assign pool_max = vmax(lb_cur, pair_max);
  assign produce  = accept & row[0] & col[0];

  // Position counters: channel -> column -> row, frame wraps to row 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch  <= '0;
      col <= '0;
      row <= '0;
    end else if (clr) begin
      ch  <= '0;
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (ch_last) begin
        ch <= '0;
        if (col_last) begin
          col <= '0;
          row <= row_last ? '0 : row + ROW_W'(1);
        end else begin
          col <= col + COL_W'(1);
        end
      end else begin
        ch <= ch + CH_W'(1);
      end
    end
  end

  // Even-column pixel of the current horizontal pair, per channel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CHANNELS; i++) hold[i] <= '0;
    end else if (accept && !col[0]) begin
      hold[ch] <= in_data;
    end
  end

  // Line buffer holds the even-row pair maxima; no reset so it maps to RAM.
  always_ff @(posedge clk) begin
    if (accept && !row[0] && col[0]) lb[lb_addr] <= pair_max;
  end

  // Single output register. A new result overwrites a value being drained
  // in the same cycle, so there is no bubble between back-to-back results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_last   <= 1'b0;
      frame_done <= 1'b0;
    end else if (clr) begin
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= out_valid & out_ready & out_last;
      if (produce) begin
        out_valid <= 1'b1;
        out_data  <= pool_max;
        out_last  <= is_last;
      end else if (out_ready) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_max_pool_2x2_stream.sv
// Bench for max_pool_2x2_stream. Four instances share one clock and reset:
//   d0: 4x4, 1 channel, signed   (basic, backpressure, abort, async reset)
//   d1: 2x2, 1 channel, signed   (signed compare)
//   d2: 2x2, 1 channel, unsigned (unsigned compare)
//   d3: 4x2, 2 channels, signed  (channel interleave)
module tb_max_pool_2x2_stream;

  localparam int N = 4;

  logic        clk;
  logic        rst_n;
  logic        clr;
  logic        in_valid   [N];
  logic        in_ready   [N];
  logic [15:0] in_data    [N];
  logic        out_valid  [N];
  logic        out_ready  [N];
  logic [15:0] out_data   [N];
  logic        out_last   [N];
  logic        frame_done [N];

  int n_checks = 0;
  int n_fail   = 0;
  int got_cnt [N];
  logic prev_acc [N];

  // {last, data} expected per instance
  logic [16:0] exp_q0 [$];
  logic [16:0] exp_q1 [$];
  logic [16:0] exp_q2 [$];
  logic [16:0] exp_q3 [$];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- DUTs ----------------
  max_pool_2x2_stream #(.DATA_W(16), .IMG_W(4), .IMG_H(4), .CHANNELS(1), .SIGNED(1)) u_d0 (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
    .out_last(out_last[0]), .frame_done(frame_done[0]));

  max_pool_2x2_stream #(.DATA_W(16), .IMG_W(2), .IMG_H(2), .CHANNELS(1), .SIGNED(1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
    .out_last(out_last[1]), .frame_done(frame_done[1]));

  max_pool_2x2_stream #(.DATA_W(16), .IMG_W(2), .IMG_H(2), .CHANNELS(1), .SIGNED(0)) u_d2 (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_data(in_data[2]),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_data(out_data[2]),
    .out_last(out_last[2]), .frame_done(frame_done[2]));

  max_pool_2x2_stream #(.DATA_W(16), .IMG_W(4), .IMG_H(2), .CHANNELS(2), .SIGNED(1)) u_d3 (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid[3]), .in_ready(in_ready[3]), .in_data(in_data[3]),
    .out_valid(out_valid[3]), .out_ready(out_ready[3]), .out_data(out_data[3]),
    .out_last(out_last[3]), .frame_done(frame_done[3]));

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_checks++;
    if (obs !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, want);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic expect_out(input int d, input logic [15:0] v, input logic last);
    case (d)
      0: exp_q0.push_back({last, v});
      1: exp_q1.push_back({last, v});
      2: exp_q2.push_back({last, v});
      default: exp_q3.push_back({last, v});
    endcase
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input int d, input logic [15:0] v);
    int n;
    n = 0;
    in_valid[d] = 1'b1;
    in_data[d]  = v;
    @(negedge clk);
    while (!in_ready[d] && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready[d]) check($sformatf("d%0d_in_ready_timeout", d), 32'(in_ready[d]), 32'd1);
    @(posedge clk);
    #1;
    in_valid[d] = 1'b0;
  endtask

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk) begin
    if (!rst_n) begin
      for (int d = 0; d < N; d++) prev_acc[d] = 1'b0;
    end else begin
      for (int d = 0; d < N; d++) begin
        logic [16:0] want;
        logic        have;
        check($sformatf("d%0d_frame_done", d), 32'(frame_done[d]), 32'(prev_acc[d]));
        prev_acc[d] = out_valid[d] & out_ready[d] & out_last[d] & ~clr;
        if (out_valid[d] && out_ready[d]) begin
          got_cnt[d]++;
          have = 1'b0;
          want = '0;
          case (d)
            0: if (exp_q0.size() > 0) begin want = exp_q0.pop_front(); have = 1'b1; end
            1: if (exp_q1.size() > 0) begin want = exp_q1.pop_front(); have = 1'b1; end
            2: if (exp_q2.size() > 0) begin want = exp_q2.pop_front(); have = 1'b1; end
            default: if (exp_q3.size() > 0) begin want = exp_q3.pop_front(); have = 1'b1; end
          endcase
          if (have) check($sformatf("d%0d_out", d), 32'({out_last[d], out_data[d]}), 32'(want));
        end
      end
    end
  end

  // ---------------- stimulus tables ----------------
  logic [15:0] bp_tab [16] = '{16'd3, 16'd9, 16'd1, 16'd4, 16'd8, 16'd2, 16'd6, 16'd0,
                               16'd11, 16'd5, 16'd14, 16'd7, 16'd10, 16'd12, 16'd13, 16'd15};
  logic [15:0] bp_exp [4]  = '{16'd9, 16'd6, 16'd12, 16'd15};

  logic [15:0] f2_tab [16] = '{16'hFFFD, 16'hFFFF, 16'hFFF9, 16'hFFFE,
                               16'hFFFF, 16'h0001, 16'h0000, 16'hFFFE,
                               16'h8000, 16'h7FFF, 16'h0000, 16'h0001,
                               16'h0005, 16'h0005, 16'h0005, 16'h0005};
  logic [15:0] f2_exp_s [4] = '{16'hFFFF, 16'h0001, 16'h7FFF, 16'h0005};
  logic [15:0] f2_exp_u [4] = '{16'hFFFF, 16'hFFFF, 16'h8000, 16'h0005};

  task automatic basic_frame_d0();
    expect_out(0, 16'd5, 1'b0);
    expect_out(0, 16'd7, 1'b0);
    expect_out(0, 16'd13, 1'b0);
    expect_out(0, 16'd15, 1'b1);
    for (int i = 0; i < 16; i++) send(0, 16'(i));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst_n = 1'b0;
    clr   = 1'b0;
    for (int d = 0; d < N; d++) begin
      in_valid[d]  = 1'b0;
      in_data[d]   = '0;
      out_ready[d] = 1'b1;
      got_cnt[d]   = 0;
      prev_acc[d]  = 1'b0;
    end

    repeat (3) @(negedge clk);
    for (int d = 0; d < N; d++) begin
      check($sformatf("d%0d_rst_in_ready", d), 32'(in_ready[d]), 32'd0);
      check($sformatf("d%0d_rst_out_valid", d), 32'(out_valid[d]), 32'd0);
    end
    check("d0_rst_out_data", 32'(out_data[0]), 32'd0);
    check("d0_rst_out_last", 32'(out_last[0]), 32'd0);
    check("d0_rst_frame_done", 32'(frame_done[0]), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("d0_in_ready_after_rst", 32'(in_ready[0]), 32'd1);
    @(posedge clk);
    #1;

    fork
      basic_frame_d0();
      begin
        for (int f = 0; f < 4; f++) begin
          expect_out(1, f2_exp_s[f], 1'b1);
          for (int i = 0; i < 4; i++) send(1, f2_tab[f*4+i]);
        end
      end
      begin
        for (int f = 0; f < 4; f++) begin
          expect_out(2, f2_exp_u[f], 1'b1);
          for (int i = 0; i < 4; i++) send(2, f2_tab[f*4+i]);
        end
      end
      begin
        for (int k = 0; k < 2; k++) begin
          expect_out(3, 16'(5 + 20*k), 1'b0);
          expect_out(3, 16'd100, 1'b0);
          expect_out(3, 16'(7 + 20*k), 1'b0);
          expect_out(3, 16'd98, 1'b1);
          for (int p = 0; p < 8; p++) begin
            send(3, 16'(20*k + p));
            send(3, 16'(100 - p));
          end
        end
      end
    join
    repeat (4) @(posedge clk);
    #1;

    // Backpressure: each result held 5 cycles before it is accepted.
    for (int i = 0; i < 4; i++) expect_out(0, bp_exp[i], i == 3);
    out_ready[0] = 1'b0;
    fork
      begin
        for (int i = 0; i < 16; i++) send(0, bp_tab[i]);
      end
      begin
        for (int k = 0; k < 4; k++) begin
          logic [15:0] snap;
          int n;
          n = 0;
          @(negedge clk);
          while (!out_valid[0] && n < 200) begin
            @(negedge clk);
            n++;
          end
          if (!out_valid[0]) check("bp_out_valid_timeout", 32'(out_valid[0]), 32'd1);
          snap = out_data[0];
          repeat (5) begin
            @(negedge clk);
            check("bp_in_ready_low", 32'(in_ready[0]), 32'd0);
            check("bp_out_data_stable", 32'(out_data[0]), 32'(snap));
          end
          @(posedge clk);
          #1;
          out_ready[0] = 1'b1;
          @(posedge clk);
          #1;
          out_ready[0] = 1'b0;
        end
      end
    join
    repeat (3) @(posedge clk);
    #1;

    // Abort after 6 pixels with a result pending, then a fresh frame.
    for (int i = 0; i < 6; i++) send(0, 16'(40 + i));
    @(negedge clk);
    check("lat_out_valid", 32'(out_valid[0]), 32'd1);
    check("lat_out_data", 32'(out_data[0]), 32'd45);
    check("pending_in_ready", 32'(in_ready[0]), 32'd0);
    @(posedge clk);
    #1;
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    @(negedge clk);
    check("clr_out_valid", 32'(out_valid[0]), 32'd0);
    check("clr_out_last", 32'(out_last[0]), 32'd0);
    check("clr_in_ready", 32'(in_ready[0]), 32'd1);
    @(posedge clk);
    #1;
    out_ready[0] = 1'b1;
    basic_frame_d0();
    repeat (3) @(posedge clk);
    #1;

    // Async reset mid-frame with a pending result, no clock edge involved.
    out_ready[0] = 1'b0;
    for (int i = 0; i < 6; i++) send(0, 16'(40 + i));
    #2;
    check("pre_rst_out_valid", 32'(out_valid[0]), 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", 32'(out_valid[0]), 32'd0);
    check("async_rst_out_data", 32'(out_data[0]), 32'd0);
    check("async_rst_in_ready", 32'(in_ready[0]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    out_ready[0] = 1'b1;
    basic_frame_d0();
    repeat (5) @(negedge clk);

    check("d0_out_count", 32'(got_cnt[0]), 32'd16);
    check("d1_out_count", 32'(got_cnt[1]), 32'd4);
    check("d2_out_count", 32'(got_cnt[2]), 32'd4);
    check("d3_out_count", 32'(got_cnt[3]), 32'd8);
    check("d0_exp_left", 32'(exp_q0.size()), 32'd0);
    check("d1_exp_left", 32'(exp_q1.size()), 32'd0);
    check("d2_exp_left", 32'(exp_q2.size()), 32'd0);
    check("d3_exp_left", 32'(exp_q3.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
